// File: rtl/mul16_seq_pkg.sv
// ============================================================================
// Module   : mul16_seq_pkg
// Purpose  : Shared types and constants for the sequential 16x16 multiplier.
//            Holds the FSM state enum, the datapath width and the 6-bit ALU
//            control words, ordered {za, na, zb, nb, f, no}.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul16_seq_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  // Counter value of the final multiplier bit.
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  // ZERO: both operands forced to zero and added, so out = 0.
  localparam logic [5:0] ALU_ZERO   = 6'b101010;
  // ADD: out = x + y.
  localparam logic [5:0] ALU_ADD    = 6'b000010;
  // PASS_X: y forced to all ones and ANDed with x, so out = x.
  localparam logic [5:0] ALU_PASS_X = 6'b001100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADD  = 2'd1,
    ST_DBL  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage : mul16_seq_pkg

`default_nettype wire

// File: rtl/alu16.sv
// ============================================================================
// Module   : alu16
// Purpose  : Combinational 16-bit datapath ALU. Each operand can be zeroed
//            and/or inverted, then added or ANDed, and the result optionally
//            inverted. zr flags a zero result, ng copies the sign bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        za,
  input  logic        na,
  input  logic        zb,
  input  logic        nb,
  input  logic        f,
  input  logic        no,
  output logic [15:0] out,
  output logic        zr,
  output logic        ng
);

  logic [15:0] w_x_z;
  logic [15:0] w_x_n;
  logic [15:0] w_y_z;
  logic [15:0] w_y_n;
  logic [15:0] w_f;

  // Operand conditioning, function select and output inversion.
  always_comb begin
    w_x_z = za ? 16'h0000 : x;
    w_x_n = na ? ~w_x_z : w_x_z;
    w_y_z = zb ? 16'h0000 : y;
    w_y_n = nb ? ~w_y_z : w_y_z;
    w_f   = f ? (w_x_n + w_y_n) : (w_x_n & w_y_n);
    out   = no ? ~w_f : w_f;
    zr    = (out == 16'h0000);
    ng    = out[15];
  end

endmodule : alu16

`default_nettype wire

// File: rtl/mul16_seq.sv
// ============================================================================
// Module   : mul16_seq
// Purpose  : Multi-cycle 16x16 shift-and-add multiplier returning the low
//            16 bits of the product. All arithmetic is delegated to an
//            external combinational ALU through the alu_* ports; this block
//            only sequences operands and control words and latches results.
// Config   : MUL16_EARLY_EXIT_EN - when defined, the run terminates as soon
//            as the remaining multiplier bits are all zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul16_seq
  import mul16_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic             zr,
  output logic             ng,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_za,
  output logic             alu_na,
  output logic             alu_zb,
  output logic             alu_nb,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zr,
  input  logic             alu_ng
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_product;
  logic             r_zr;
  logic             r_ng;
  logic [5:0]       w_ctrl;
  logic [WIDTH-1:0] w_mplier_shr;

  assign w_mplier_shr = r_mplier >> 1;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and ALU operand/control decode for the current step.
  always_comb begin
    w_state_nxt = r_state;
    w_ctrl      = ALU_ZERO;
    alu_x       = '0;
    alu_y       = '0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
`ifdef MUL16_EARLY_EXIT_EN
          w_state_nxt = (op_b == '0) ? ST_DONE : ST_ADD;
`else
          w_state_nxt = ST_ADD;
`endif
        end
      end
      ST_ADD: begin
        alu_x       = r_acc;
        alu_y       = r_mcand;
        w_ctrl      = r_mplier[0] ? ALU_ADD : ALU_PASS_X;
        w_state_nxt = ST_DBL;
      end
      ST_DBL: begin
        alu_x  = r_mcand;
        alu_y  = r_mcand;
        w_ctrl = ALU_ADD;
`ifdef MUL16_EARLY_EXIT_EN
        if (r_cnt == LAST_BIT || w_mplier_shr == '0) begin
`else
        if (r_cnt == LAST_BIT) begin
`endif
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_ADD;
        end
      end
      ST_DONE: begin
        // Route the accumulator through the ALU so zr/ng come from its flags.
        alu_x       = r_acc;
        w_ctrl      = ALU_PASS_X;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign {alu_za, alu_na, alu_zb, alu_nb, alu_f, alu_no} = w_ctrl;

  // Datapath registers: operand capture, accumulate, double/shift, result latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc     <= '0;
      r_mcand   <= '0;
      r_mplier  <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_zr      <= 1'b0;
      r_ng      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_acc    <= '0;
            r_mcand  <= op_a;
            r_mplier <= op_b;
            r_cnt    <= '0;
          end
        end
        ST_ADD: begin
          r_acc <= alu_out;
        end
        ST_DBL: begin
          r_mcand  <= alu_out;
          r_mplier <= w_mplier_shr;
          r_cnt    <= r_cnt + 1'b1;
        end
        ST_DONE: begin
          r_product <= r_acc;
          r_zr      <= alu_zr;
          r_ng      <= alu_ng;
        end
        default: begin
        end
      endcase
    end
  end

  // The result is already valid in DONE, ahead of the holding registers.
  assign busy    = (r_state != ST_IDLE);
  assign done    = (r_state == ST_DONE);
  assign product = done ? r_acc  : r_product;
  assign zr      = done ? alu_zr : r_zr;
  assign ng      = done ? alu_ng : r_ng;

endmodule : mul16_seq

`default_nettype wire

// File: tb/tb_mul16_seq.sv
// ============================================================================
// Module   : tb_mul16_seq
// Purpose  : Self-checking bench for mul16_seq wired to the alu16 datapath
//            ALU. Vector table plus directed sequences for ignored start and
//            mid-run reset. Honours MUL16_EARLY_EXIT_EN for latency checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        busy;
  logic        done;
  logic [15:0] product;
  logic        zr;
  logic        ng;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic        alu_za, alu_na, alu_zb, alu_nb, alu_f, alu_no;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] p;
    logic        z;
    logic        n;
  } vec_t;

  vec_t vecs [10];

  mul16_seq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .op_a    (op_a),
    .op_b    (op_b),
    .busy    (busy),
    .done    (done),
    .product (product),
    .zr      (zr),
    .ng      (ng),
    .alu_x   (alu_x),
    .alu_y   (alu_y),
    .alu_za  (alu_za),
    .alu_na  (alu_na),
    .alu_zb  (alu_zb),
    .alu_nb  (alu_nb),
    .alu_f   (alu_f),
    .alu_no  (alu_no),
    .alu_out (alu_out),
    .alu_zr  (alu_zr),
    .alu_ng  (alu_ng)
  );

  alu16 u_alu (
    .x   (alu_x),
    .y   (alu_y),
    .za  (alu_za),
    .na  (alu_na),
    .zb  (alu_zb),
    .nb  (alu_nb),
    .f   (alu_f),
    .no  (alu_no),
    .out (alu_out),
    .zr  (alu_zr),
    .ng  (alu_ng)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Edge index (edge 0 = accepting edge) after which done is expected high.
  function automatic int exp_latency(input logic [15:0] b);
`ifdef MUL16_EARLY_EXIT_EN
    int msb;
    msb = -1;
    for (int i = 0; i < 16; i++) if (b[i]) msb = i;
    return (msb < 0) ? 0 : 2 * (msb + 1);
`else
    return 32;
`endif
  endfunction

  // One multiply: returns result captured in the done cycle, latency and
  // number of done pulses over a fixed window.
  task automatic do_run(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] p, output logic z, output logic n,
                        output int lat, output int pulses, output logic busy1);
    @(negedge clk);
    op_a  = a;
    op_b  = b;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    lat    = -1;
    pulses = 0;
    p      = 'x;
    z      = 1'bx;
    n      = 1'bx;
    busy1  = busy;
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          p   = product;
          z   = zr;
          n   = ng;
        end
      end
      @(negedge clk);
    end
  endtask

  initial begin
    logic [15:0] p;
    logic        z, n, b1;
    int          lat, pulses;

    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op_a  = 16'h0000;
    op_b  = 16'h0000;

    vecs[0] = '{16'h0003, 16'h0005, 16'h000F, 1'b0, 1'b0};
    vecs[1] = '{16'hFFFF, 16'h0002, 16'hFFFE, 1'b0, 1'b1};
    vecs[2] = '{16'h0100, 16'h0100, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h1234, 16'h0001, 16'h1234, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h0000, 16'h0000, 1'b1, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{16'h7FFF, 16'h0003, 16'h7FFD, 1'b0, 1'b0};
    vecs[7] = '{16'h00FF, 16'h0101, 16'hFFFF, 1'b0, 1'b1};
    vecs[8] = '{16'hABCD, 16'h8000, 16'h8000, 1'b0, 1'b1};
    vecs[9] = '{16'h0000, 16'hFFFF, 16'h0000, 1'b1, 1'b0};

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_product", 32'(product), 32'd0);
    check("rst_zr", 32'(zr), 32'd0);
    check("rst_ng", 32'(ng), 32'd0);
    check("rst_ctrl", 32'({alu_za, alu_na, alu_zb, alu_nb, alu_f, alu_no}), 32'b101010);
    check("rst_alu_xy", 32'({alu_x, alu_y}), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      do_run(vecs[i].a, vecs[i].b, p, z, n, lat, pulses, b1);
      check($sformatf("v%0d_product", i), 32'(p), 32'(vecs[i].p));
      check($sformatf("v%0d_zr", i), 32'(z), 32'(vecs[i].z));
      check($sformatf("v%0d_ng", i), 32'(n), 32'(vecs[i].n));
      check($sformatf("v%0d_latency", i), 32'(lat), 32'(exp_latency(vecs[i].b)));
      check($sformatf("v%0d_pulses", i), 32'(pulses), 32'd1);
      check($sformatf("v%0d_busy_first", i), 32'(b1), 32'd1);
      check($sformatf("v%0d_held_product", i), 32'(product), 32'(vecs[i].p));
      check($sformatf("v%0d_idle_busy", i), 32'(busy), 32'd0);
    end

    // Start during an active run is ignored.
    @(negedge clk);
    op_a  = 16'h0003;
    op_b  = 16'h8005;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    lat    = -1;
    pulses = 0;
    p      = 16'h0000;
    for (int k = 0; k < 45; k++) begin
      if (done) begin
        pulses++;
        if (lat < 0) begin
          lat = k;
          p   = product;
        end
      end
      start = 1'b0;
      if (k == 9) begin
        op_a  = 16'h1111;
        op_b  = 16'h2222;
        start = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_product", 32'(p), 32'h800F);
    check("ign_pulses", 32'(pulses), 32'd1);
    check("ign_latency", 32'(lat), 32'd32);
    check("ign_held", 32'(product), 32'h800F);
    check("ign_ng", 32'(ng), 32'd1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    op_a  = 16'h0003;
    op_b  = 16'h8005;
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_product", 32'(product), 32'd0);
    check("mid_rst_ng", 32'(ng), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_product", 32'(product), 32'd0);
    do_run(16'h0003, 16'h0005, p, z, n, lat, pulses, b1);
    check("post_rst_run_product", 32'(p), 32'h000F);
    check("post_rst_run_latency", 32'(lat), 32'(exp_latency(16'h0005)));
    check("post_rst_run_pulses", 32'(pulses), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule : tb_mul16_seq

`default_nettype wire
